// File: rtl/conv_buf_pkg.sv
// Shared types and helpers for the K x K convolution window buffer.
// The width constants describe the default 26 x 26 geometry.
package conv_buf_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD_W = 2'd1,
      S_STREAM = 2'd2
   } state_e;

   localparam int DEF_K        = 3;
   localparam int DEF_MAX_COLS = 26;
   localparam int DEF_MAX_ROWS = 26;
   localparam int COLS_W       = $clog2(DEF_MAX_COLS + 1);
   localparam int ROWS_W       = $clog2(DEF_MAX_ROWS + 1);
   localparam int DL_IDX_W     =
      $clog2((DEF_K - 1) * DEF_MAX_COLS + DEF_K + 1);

   // Distance of tap (r,c) from the newest pixel in the delay line
   function automatic int tap_off(input int r, input int c,
                                  input int cols, input int k);
      return (k - 1 - r) * cols + (k - 1 - c);
   endfunction

endpackage

// File: rtl/tap_delay_line.sv
// Enable-gated pixel shift register; entry 0 is the newest pixel.
// The clear input only resets the fill count, not the stored data.
module tap_delay_line #(
   parameter int DW    = 8,
   parameter int DEPTH = 55
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr_i,
   input  logic                         en_i,
   input  logic [DW-1:0]                d_i,
   output logic [DW*DEPTH-1:0]          line_o,
   output logic [$clog2(DEPTH+1)-1:0]   fill_o
);

   localparam int FW = $clog2(DEPTH + 1);

   logic [DW*DEPTH-1:0] line_q;
   logic [FW-1:0]       fill_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         line_q <= '0;
         fill_q <= '0;
      end else begin
         if (en_i)
            line_q <= {line_q[DW*(DEPTH-1)-1:0], d_i};
         if (clr_i)
            fill_q <= '0;
         else if (en_i && fill_q != FW'(DEPTH))
            fill_q <= fill_q + FW'(1);
      end
   end

   assign line_o = line_q;
   assign fill_o = fill_q;

endmodule

// File: rtl/conv_window_buffer.sv
// Loads a K x K weight set, then streams pixels through a line buffer
// and emits every valid K x K window with its top-left coordinate.
module conv_window_buffer
   import conv_buf_pkg::*;
#(
   parameter int DW       = 8,
   parameter int K        = DEF_K,
   parameter int MAX_COLS = DEF_MAX_COLS,
   parameter int MAX_ROWS = DEF_MAX_ROWS
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_start,
   input  logic [$clog2(MAX_COLS+1)-1:0] i_cols,
   input  logic [$clog2(MAX_ROWS+1)-1:0] i_rows,
   input  logic                          i_valid,
   output logic                          i_ready,
   input  logic [DW-1:0]                 i_data,
   output logic                          o_valid,
   output logic [K*K*DW-1:0]             o_weight,
   output logic [K*K*DW-1:0]             o_window,
   output logic [$clog2(MAX_ROWS)-1:0]   o_row,
   output logic [$clog2(MAX_COLS)-1:0]   o_col,
   output logic                          o_done,
   output logic                          o_err
);

   localparam int CW    = $clog2(MAX_COLS + 1);
   localparam int RW    = $clog2(MAX_ROWS + 1);
   localparam int OCW   = $clog2(MAX_COLS);
   localparam int ORW   = $clog2(MAX_ROWS);
   localparam int KK    = K * K;
   localparam int WCW   = $clog2(KK);
   localparam int DEPTH = (K - 1) * MAX_COLS + K;
   localparam int FW    = $clog2(DEPTH + 1);
   localparam int IW    = $clog2(DEPTH + 1);

   state_e              state_q;
   logic [CW-1:0]       cols_q;
   logic [RW-1:0]       rows_q;
   logic [WCW-1:0]      wcnt_q;
   logic [CW-1:0]       in_col_q;
   logic [RW-1:0]       in_row_q;
   logic [KK*DW-1:0]    wsh_q;
   logic [KK*DW-1:0]    weight_q;
   logic [KK*DW-1:0]    window_q;
   logic [ORW-1:0]      o_row_q;
   logic [OCW-1:0]      o_col_q;
   logic                valid_q;
   logic                done_q;
   logic                err_q;

   logic [DW*DEPTH-1:0] line;
   logic [FW-1:0]       fill;
   logic [DW-1:0]       ext [DEPTH+1];
   logic [KK*DW-1:0]    win_d;
   logic [KK*DW-1:0]    wsh_d;
   logic [RW-1:0]       row_off;
   logic [CW-1:0]       col_off;
   logic                accept;
   logic                geom_ok;
   logic                emit_ok;
   logic                col_last;
   logic                last_pix;

   assign i_ready = (state_q != S_IDLE);
   assign accept  = i_valid & i_ready & ~i_start;

   assign geom_ok = (int'(i_cols) >= K) && (int'(i_cols) <= MAX_COLS) &&
                    (int'(i_rows) >= K) && (int'(i_rows) <= MAX_ROWS);

   tap_delay_line #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_dl (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (i_start & geom_ok),
      .en_i   (accept & (state_q == S_STREAM)),
      .d_i    (i_data),
      .line_o (line),
      .fill_o (fill)
   );

   // Offset 0 is the pixel being accepted right now
   always_comb begin
      ext[0] = i_data;
      for (int i = 1; i <= DEPTH; i++)
         ext[i] = line[(i-1)*DW +: DW];
   end

   always_comb begin
      win_d = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K; c++) begin
            win_d[(r*K+c)*DW +: DW] =
               ext[IW'(tap_off(r, c, int'(cols_q), K))];
         end
      end
   end

   assign wsh_d    = {i_data, wsh_q[KK*DW-1:DW]};
   assign row_off  = in_row_q - RW'(K - 1);
   assign col_off  = in_col_q - CW'(K - 1);
   assign col_last = (in_col_q == cols_q - CW'(1));
   assign last_pix = col_last && (in_row_q == rows_q - RW'(1));
   assign emit_ok  = (in_row_q >= RW'(K - 1)) &&
                     (in_col_q >= CW'(K - 1)) &&
                     (int'(fill) >= tap_off(0, 0, int'(cols_q), K));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cols_q   <= '0;
         rows_q   <= '0;
         wcnt_q   <= '0;
         in_col_q <= '0;
         in_row_q <= '0;
         wsh_q    <= '0;
         weight_q <= '0;
         window_q <= '0;
         o_row_q  <= '0;
         o_col_q  <= '0;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         if (i_start) begin
            if (geom_ok) begin
               cols_q   <= i_cols;
               rows_q   <= i_rows;
               wcnt_q   <= '0;
               in_col_q <= '0;
               in_row_q <= '0;
               state_q  <= S_LOAD_W;
            end else begin
               err_q   <= 1'b1;
               state_q <= S_IDLE;
            end
         end else if (accept) begin
            unique case (state_q)
               S_LOAD_W: begin
                  wsh_q <= wsh_d;
                  if (wcnt_q == WCW'(KK - 1)) begin
                     wcnt_q   <= '0;
                     weight_q <= wsh_d;
                     state_q  <= S_STREAM;
                  end else begin
                     wcnt_q <= wcnt_q + WCW'(1);
                  end
               end
               S_STREAM: begin
                  if (emit_ok) begin
                     valid_q  <= 1'b1;
                     window_q <= win_d;
                     o_row_q  <= row_off[ORW-1:0];
                     o_col_q  <= col_off[OCW-1:0];
                  end
                  if (col_last) begin
                     in_col_q <= '0;
                     in_row_q <= in_row_q + RW'(1);
                  end else begin
                     in_col_q <= in_col_q + CW'(1);
                  end
                  if (last_pix) begin
                     in_row_q <= '0;
                     done_q   <= 1'b1;
                     state_q  <= S_IDLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign o_valid  = valid_q;
   assign o_weight = weight_q;
   assign o_window = window_q;
   assign o_row    = o_row_q;
   assign o_col    = o_col_q;
   assign o_done   = done_q;
   assign o_err    = err_q;

endmodule

// File: tb/tb_conv_window_buffer.sv
// Directed bench for conv_window_buffer with a window scoreboard
// filled from a reference image model as pixels are driven.
module tb_conv_window_buffer;
   import conv_buf_pkg::*;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              i_start = 1'b0;
   logic [COLS_W-1:0] i_cols = '0;
   logic [ROWS_W-1:0] i_rows = '0;
   logic              i_valid = 1'b0;
   logic              i_ready;
   logic [7:0]        i_data = '0;
   logic              o_valid;
   logic [71:0]       o_weight;
   logic [71:0]       o_window;
   logic [4:0]        o_row;
   logic [4:0]        o_col;
   logic              o_done;
   logic              o_err;

   conv_window_buffer dut (
      .clk      (clk),
      .rst      (rst),
      .i_start  (i_start),
      .i_cols   (i_cols),
      .i_rows   (i_rows),
      .i_valid  (i_valid),
      .i_ready  (i_ready),
      .i_data   (i_data),
      .o_valid  (o_valid),
      .o_weight (o_weight),
      .o_window (o_window),
      .o_row    (o_row),
      .o_col    (o_col),
      .o_done   (o_done),
      .o_err    (o_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  r;
      logic [4:0]  c;
      logic [71:0] w;
   } exp_t;

   exp_t        sbq[$];
   logic [7:0]  img [0:25][0:25];
   int          checks = 0;
   int          errors = 0;
   int          win_cnt = 0;
   int          done_cnt = 0;
   logic [71:0] first_win;
   logic [71:0] last_win;
   logic [4:0]  last_r;
   logic [4:0]  last_c;
   logic        acc_prev = 1'b0;

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [71:0] wexp(input int base);
      logic [71:0] w;
      for (int n = 0; n < 9; n++)
         w[n*8 +: 8] = 8'(base + n);
      return w;
   endfunction

   always @(posedge clk)
      acc_prev <= i_valid && i_ready && !i_start;

   always @(negedge clk) begin
      if (!rst) begin
         if (o_valid) begin
            exp_t e;
            chk("valid_after_accept", 128'(acc_prev), 128'(1));
            if (sbq.size() == 0) begin
               chk("unexpected_window", 128'(o_valid), 128'(0));
            end else begin
               e = sbq.pop_front();
               chk("win_data", 128'(o_window), 128'(e.w));
               chk("win_row", 128'(o_row), 128'(e.r));
               chk("win_col", 128'(o_col), 128'(e.c));
            end
            if (win_cnt == 0) first_win = o_window;
            last_win = o_window;
            last_r   = o_row;
            last_c   = o_col;
            win_cnt++;
         end
         if (o_done) begin
            done_cnt++;
            chk("done_with_valid", 128'(o_valid), 128'(1));
         end
      end
   end

   task automatic start(input int cols, input int rows);
      i_start = 1'b1;
      i_cols  = COLS_W'(cols);
      i_rows  = ROWS_W'(rows);
      tick();
      i_start = 1'b0;
   endtask

   task automatic load_w(input int base, input int first, input int n);
      for (int k = first; k < first + n; k++) begin
         i_valid = 1'b1;
         i_data  = 8'(base + k);
         tick();
      end
      i_valid = 1'b0;
   endtask

   task automatic send_pix(input int r, input int c, input logic [7:0] v);
      exp_t e;
      img[r][c] = v;
      i_valid   = 1'b1;
      i_data    = v;
      if (r >= 2 && c >= 2) begin
         e.r = 5'(r - 2);
         e.c = 5'(c - 2);
         for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++)
               e.w[(rr*3+cc)*8 +: 8] = img[r-2+rr][c-2+cc];
         sbq.push_back(e);
      end
      tick();
   endtask

   // mode 0: value = row*16+col, otherwise random pixels
   task automatic stream_frame(input int rows, input int cols,
                               input int mode, input bit gaps);
      for (int r = 0; r < rows; r++) begin
         for (int c = 0; c < cols; c++) begin
            if (gaps) begin
               while ($urandom_range(0, 2) == 0) begin
                  i_valid = 1'b0;
                  tick();
               end
            end
            if (mode == 0)
               send_pix(r, c, 8'(r * 16 + c));
            else
               send_pix(r, c, 8'($urandom));
         end
      end
      i_valid = 1'b0;
   endtask

   initial begin
      // Reset state
      tick();
      rst = 1'b0;
      chk("rst_ready", 128'(i_ready), 128'(0));
      chk("rst_valid", 128'(o_valid), 128'(0));
      chk("rst_weight", 128'(o_weight), 128'(0));
      chk("rst_window", 128'(o_window), 128'(0));
      chk("rst_done_err", 128'({o_done, o_err}), 128'(0));

      // 5x5 frame, weights 1..9, pixels row*16+col
      start(5, 5);
      chk("a_ready_load", 128'(i_ready), 128'(1));
      load_w(1, 0, 9);
      chk("a_weight", 128'(o_weight), 128'(wexp(1)));
      win_cnt  = 0;
      done_cnt = 0;
      stream_frame(5, 5, 0, 1'b0);
      chk("a_done_now", 128'(o_done), 128'(1));
      tick();
      tick();
      chk("a_win_cnt", 128'(win_cnt), 128'(9));
      chk("a_done_cnt", 128'(done_cnt), 128'(1));
      chk("a_first_tl", 128'(first_win[7:0]), 128'(8'h00));
      chk("a_first_br", 128'(first_win[71:64]), 128'(8'h22));
      chk("a_last_br", 128'(last_win[71:64]), 128'(8'h44));
      chk("a_last_pos", 128'({last_r, last_c}), 128'({5'd2, 5'd2}));
      chk("a_idle", 128'(i_ready), 128'(0));
      chk("a_sb_empty", 128'(sbq.size()), 128'(0));

      // Widest row, 3 rows, random gaps
      start(26, 3);
      load_w(8'h60, 0, 9);
      win_cnt  = 0;
      done_cnt = 0;
      stream_frame(3, 26, 1, 1'b1);
      tick();
      tick();
      chk("b_win_cnt", 128'(win_cnt), 128'(24));
      chk("b_last_col", 128'(last_c), 128'(23));
      chk("b_done_cnt", 128'(done_cnt), 128'(1));
      chk("b_sb_empty", 128'(sbq.size()), 128'(0));

      // Illegal geometry
      start(2, 5);
      chk("e_err_small", 128'(o_err), 128'(1));
      chk("e_ready_small", 128'(i_ready), 128'(0));
      tick();
      chk("e_err_pulse", 128'(o_err), 128'(0));
      start(27, 5);
      chk("e_err_large", 128'(o_err), 128'(1));
      chk("e_ready_large", 128'(i_ready), 128'(0));
      tick();

      // Abort after the 7th pixel
      start(5, 5);
      load_w(8'h10, 0, 9);
      for (int n = 0; n < 7; n++)
         send_pix(n / 5, n % 5, 8'($urandom));
      i_valid = 1'b0;
      start(5, 5);
      chk("ab_ready", 128'(i_ready), 128'(1));
      load_w(8'h20, 0, 8);
      chk("ab_w_hold", 128'(o_weight), 128'(wexp(8'h10)));
      load_w(8'h20, 8, 1);
      chk("ab_w_new", 128'(o_weight), 128'(wexp(8'h20)));
      win_cnt  = 0;
      done_cnt = 0;
      stream_frame(5, 5, 1, 1'b0);
      tick();
      tick();
      chk("ab_win_cnt", 128'(win_cnt), 128'(9));
      chk("ab_done_cnt", 128'(done_cnt), 128'(1));

      // i_start and i_valid together during STREAM
      start(5, 5);
      load_w(8'h40, 0, 9);
      for (int n = 0; n < 3; n++)
         send_pix(0, n, 8'($urandom));
      i_start = 1'b1;
      i_valid = 1'b1;
      i_data  = 8'hEE;
      tick();
      i_start = 1'b0;
      i_valid = 1'b0;
      load_w(8'h50, 0, 8);
      chk("sv_w_hold", 128'(o_weight), 128'(wexp(8'h40)));
      load_w(8'h50, 8, 1);
      chk("sv_w_new", 128'(o_weight), 128'(wexp(8'h50)));

      // Reset in the middle of STREAM
      for (int n = 0; n < 4; n++)
         send_pix(0, n, 8'($urandom));
      i_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mr_ready", 128'(i_ready), 128'(0));
      chk("mr_outs", 128'({o_valid, o_done, o_err, o_row, o_col}),
          128'(0));
      chk("mr_weight", 128'(o_weight), 128'(0));
      chk("mr_window", 128'(o_window), 128'(0));
      chk("mr_sb_empty", 128'(sbq.size()), 128'(0));
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
